// File: rtl/pc_sequencer_if.sv
// Next-PC sequencer bundle: run/hazard/branch inputs, PC controls and perf counters.
// master drives the request side, slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [31:0]      pc_i;
  logic             imem_ready_i;
  logic             hazard_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      pc_next_o;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             IFFlush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, pc_i, imem_ready_i,
    output hazard_i, branch_taken_i,
    output branch_target_i,
    input  pc_next_o, PCWrite_o,
    input  IFIDWrite_o, IFFlush_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, pc_i, imem_ready_i,
    input  hazard_i, branch_taken_i,
    input  branch_target_i,
    output pc_next_o, PCWrite_o,
    output IFIDWrite_o, IFFlush_o,
    output stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, branch redirect, load-use stall, imem wait.
// A redirect seen while imem is busy is parked in pend_pc until fetch is ready.
module pc_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          CNT_W    = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state, state_nxt;
  logic [31:0]      pend_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [31:0] pc_seq, pc_next;
  logic        pc_hold, ifid_hold, flush;
  logic        stall_inc, flush_inc, to_pend;
  logic        sel_haz, sel_br, sel_park, sel_wait;

  // One-hot decode of the RUN priority chain
  always_comb begin
    sel_haz  = bus.hazard_i;
    sel_br   = !bus.hazard_i && bus.branch_taken_i
             && bus.imem_ready_i;
    sel_park = !bus.hazard_i && bus.branch_taken_i
             && !bus.imem_ready_i;
    sel_wait = !bus.hazard_i && !bus.branch_taken_i
             && !bus.imem_ready_i;
  end

  always_comb begin
    pc_seq    = bus.pc_i + PC_STEP;
    pc_next   = PC_RESET;
    pc_hold   = 1'b1;
    ifid_hold = 1'b1;
    flush     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    to_pend   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start_i) state_nxt = RUN;
      end
      RUN: begin
        if (!bus.start_i) begin
          state_nxt = IDLE;
        end else begin
          pc_next   = pc_seq;
          pc_hold   = 1'b0;
          ifid_hold = 1'b0;
          unique case (1'b1)
            sel_haz: begin
              pc_hold   = 1'b1;
              ifid_hold = 1'b1;
              stall_inc = 1'b1;
            end
            sel_br: begin
              pc_next   = bus.branch_target_i;
              flush     = 1'b1;
              flush_inc = 1'b1;
            end
            sel_park: begin
              pc_hold   = 1'b1;
              flush     = 1'b1;
              flush_inc = 1'b1;
              to_pend   = 1'b1;
              state_nxt = PEND;
            end
            sel_wait: begin
              pc_hold   = 1'b1;
              flush     = 1'b1;
              stall_inc = 1'b1;
            end
            default: ;
          endcase
        end
      end
      PEND: begin
        if (!bus.start_i) begin
          state_nxt = IDLE;
        end else begin
          pc_next   = pend_pc;
          flush     = 1'b1;
          ifid_hold = 1'b0;
          pc_hold   = !bus.imem_ready_i;
          if (bus.imem_ready_i) state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      pend_pc   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (to_pend)
        pend_pc <= bus.branch_target_i;
      else if (state_nxt == IDLE)
        pend_pc <= '0;
      if (stall_inc && !(&stall_cnt))
        stall_cnt <= stall_cnt + ONE;
      if (flush_inc && !(&flush_cnt))
        flush_cnt <= flush_cnt + ONE;
    end
  end

  assign bus.pc_next_o   = pc_next;
  assign bus.PCWrite_o   = pc_hold;
  assign bus.IFIDWrite_o = ifid_hold;
  assign bus.IFFlush_o   = flush;
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
endmodule
